// File: rtl/priv_1_12_pc_redirect.sv
// rtl/priv_1_12_pc_redirect.sv - trap entry/return PC redirect sequencer (optional PRIV_VECTORED_MTVEC_EN)
module priv_1_12_pc_redirect #(
    parameter int CAUSE_W = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        intr,
    input  logic        mret,
    input  logic        sret,
    input  logic        uret,
    input  logic        pipe_clear,
    input  logic [31:0] curr_mtvec,
    input  logic [31:0] curr_mcause,
    input  logic [31:0] curr_mepc,
    output logic        insert_pc,
    output logic [31:0] priv_pc,
    output logic        redirect_busy
);

    typedef enum logic [1:0] {IDLE, PEND, FIRE} state_t;
    typedef enum logic [1:0] {KIND_NONE, KIND_TRAP, KIND_RET} kind_t;

    state_t      state, next_state;
    kind_t       kind, next_kind;
    kind_t       req_kind, eff_kind;
    logic [31:0] next_pc;
    logic [31:0] trap_base;
    logic [31:0] trap_target;
    logic        req;

    assign trap_base = {curr_mtvec[31:2], 2'b00};

`ifdef PRIV_VECTORED_MTVEC_EN
    logic [31:0] vec_off;
    logic        unused_mcause_bits;

    always_comb begin
        vec_off = '0;
        vec_off[CAUSE_W+1:2] = curr_mcause[CAUSE_W-1:0];
    end

    // Only interrupts in mode 1 are vectored; exceptions and modes 2/3 use the base.
    assign trap_target = (curr_mtvec[1:0] == 2'b01 && curr_mcause[31])
                       ? trap_base + vec_off : trap_base;
    assign unused_mcause_bits = ^curr_mcause;
`else
    logic unused_cfg_bits;

    assign trap_target     = trap_base;
    assign unused_cfg_bits = ^{curr_mcause, curr_mtvec[1:0]};
`endif

    assign req      = intr | mret | sret | uret;
    assign req_kind = intr ? KIND_TRAP : KIND_RET;
    // A trap arriving while a return waits takes over the pending slot.
    assign eff_kind = (intr || kind == KIND_TRAP) ? KIND_TRAP : KIND_RET;

    always_comb begin
        next_state = state;
        next_kind  = kind;
        next_pc    = priv_pc;
        case (state)
            IDLE: begin
                if (req) begin
                    if (pipe_clear) begin
                        next_state = FIRE;
                        next_pc    = (req_kind == KIND_TRAP) ? trap_target : curr_mepc;
                    end else begin
                        next_state = PEND;
                        next_kind  = req_kind;
                    end
                end
            end
            PEND: begin
                if (pipe_clear) begin
                    next_state = FIRE;
                    next_kind  = KIND_NONE;
                    next_pc    = (eff_kind == KIND_TRAP) ? trap_target : curr_mepc;
                end else begin
                    next_kind = eff_kind;
                end
            end
            FIRE: begin
                // A request during the strobe must wait a full PEND pass.
                if (req) begin
                    next_state = PEND;
                    next_kind  = req_kind;
                end else begin
                    next_state = IDLE;
                    next_kind  = KIND_NONE;
                end
            end
            default: begin
                next_state = IDLE;
                next_kind  = KIND_NONE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            kind    <= KIND_NONE;
            priv_pc <= 32'h0;
        end else begin
            state   <= next_state;
            kind    <= next_kind;
            priv_pc <= next_pc;
        end
    end

    assign insert_pc     = (state == FIRE);
    assign redirect_busy = (state != IDLE);

endmodule

// File: tb/tb_priv_1_12_pc_redirect.sv
// tb/tb_priv_1_12_pc_redirect.sv - self-checking bench for priv_1_12_pc_redirect
module tb_priv_1_12_pc_redirect;

    localparam int CW = 5;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        intr = 1'b0, mret = 1'b0, sret = 1'b0, uret = 1'b0;
    logic        pipe_clear = 1'b0;
    logic [31:0] curr_mtvec = 32'h0, curr_mcause = 32'h0, curr_mepc = 32'h0;
    logic        insert_pc;
    logic [31:0] priv_pc;
    logic        redirect_busy;

    int total = 0;
    int bad   = 0;

    logic        owe = 1'b0, owe_trap = 1'b0, m_ins = 1'b0;
    logic [31:0] m_pc = 32'h0;

    priv_1_12_pc_redirect #(.CAUSE_W(CW)) dut (
        .CLK(CLK), .RST(RST), .intr(intr), .mret(mret), .sret(sret), .uret(uret),
        .pipe_clear(pipe_clear), .curr_mtvec(curr_mtvec), .curr_mcause(curr_mcause),
        .curr_mepc(curr_mepc), .insert_pc(insert_pc), .priv_pc(priv_pc),
        .redirect_busy(redirect_busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] model_trap(input logic [31:0] tv, input logic [31:0] mc);
        logic [31:0] base;
        logic [31:0] mask;
        base = tv & 32'hFFFF_FFFC;
        mask = (32'd1 << CW) - 32'd1;
`ifdef PRIV_VECTORED_MTVEC_EN
        if (tv[1:0] == 2'd1 && mc[31]) return base + 32'd4 * (mc & mask);
`endif
        return base + 32'd0 * (mc & mask);
    endfunction

    // Model: an owed redirect is served once the pipe is clear, never straight out of a strobe cycle.
    always @(posedge CLK or posedge RST) begin : model
        logic any_req, trap_now, owe_now;
        if (RST) begin
            owe <= 1'b0; owe_trap <= 1'b0; m_ins <= 1'b0; m_pc <= 32'h0;
        end else begin
            any_req  = intr | mret | sret | uret;
            trap_now = (owe && owe_trap) || intr;
            owe_now  = owe || any_req;
            if (m_ins) begin
                m_ins    <= 1'b0;
                owe      <= any_req;
                owe_trap <= intr;
            end else if (owe_now && pipe_clear) begin
                m_ins    <= 1'b1;
                m_pc     <= trap_now ? model_trap(curr_mtvec, curr_mcause) : curr_mepc;
                owe      <= 1'b0;
                owe_trap <= 1'b0;
            end else begin
                owe      <= owe_now;
                owe_trap <= trap_now;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        check("cyc_insert_pc", {31'b0, insert_pc}, {31'b0, m_ins});
        check("cyc_busy", {31'b0, redirect_busy}, {31'b0, m_ins | owe});
        check("cyc_priv_pc", priv_pc, m_pc);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fire_trap(input logic [31:0] tv, input logic [31:0] mc, input logic [31:0] lit, input string nm);
        curr_mtvec = tv; curr_mcause = mc; intr = 1'b1; pipe_clear = 1'b1;
        step();
        intr = 1'b0;
        check({nm, "_ins"}, {31'b0, insert_pc}, 32'd1);
        check({nm, "_pc"}, priv_pc, lit);
        step();
    endtask

    initial begin
        #1 RST = 1'b1;
        #1;
        check("rst_insert", {31'b0, insert_pc}, 32'd0);
        check("rst_pc", priv_pc, 32'h0);
        check("rst_busy", {31'b0, redirect_busy}, 32'd0);
        step();
        RST = 1'b0;
        step();

        // direct trap, one-cycle latency, single-cycle strobe
        fire_trap(32'h0000_0100, 32'h0000_0003, 32'h0000_0100, "trap_direct");
        check("trap_one_cycle", {31'b0, insert_pc}, 32'd0);

        // mret held while pipe busy
        curr_mepc = 32'h8000_0040; mret = 1'b1; pipe_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pend_busy", {31'b0, redirect_busy}, 32'd1);
            check("pend_no_ins", {31'b0, insert_pc}, 32'd0);
        end
        mret = 1'b0; pipe_clear = 1'b1;
        step();
        check("mret_ins", {31'b0, insert_pc}, 32'd1);
        check("mret_pc", priv_pc, 32'h8000_0040);
        step();
        check("mret_idle", {31'b0, redirect_busy}, 32'd0);

        // pending mret upgraded by intr
        pipe_clear = 1'b0; mret = 1'b1;
        step();
        mret = 1'b0; intr = 1'b1;
        step();
        intr = 1'b0; pipe_clear = 1'b1;
        step();
        check("upgrade_ins", {31'b0, insert_pc}, 32'd1);
        check("upgrade_pc", priv_pc, 32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            step();
            check("upgrade_single", {31'b0, insert_pc}, 32'd0);
        end

        // uret during a trap strobe is replayed
        curr_mepc = 32'h1234_5678; intr = 1'b1;
        step();
        intr = 1'b0; uret = 1'b1;
        check("fire_first_pc", priv_pc, 32'h0000_0100);
        step();
        uret = 1'b0;
        check("replay_pend", {31'b0, insert_pc}, 32'd0);
        check("replay_busy", {31'b0, redirect_busy}, 32'd1);
        step();
        check("replay_ins", {31'b0, insert_pc}, 32'd1);
        check("replay_pc", priv_pc, 32'h1234_5678);
        step();

        // simultaneous intr+mret: trap wins; plain sret return
        curr_mepc = 32'h0000_4000; intr = 1'b1; mret = 1'b1;
        step();
        intr = 1'b0; mret = 1'b0;
        check("prio_pc", priv_pc, 32'h0000_0100);
        step();
        sret = 1'b1;
        step();
        sret = 1'b0;
        check("sret_pc", priv_pc, 32'h0000_4000);
        step();

        // reset while pending
        pipe_clear = 1'b0; sret = 1'b1;
        step();
        sret = 1'b0;
        check("rst_pend_busy", {31'b0, redirect_busy}, 32'd1);
        #2 RST = 1'b1;
        #1;
        check("async_insert", {31'b0, insert_pc}, 32'd0);
        check("async_busy", {31'b0, redirect_busy}, 32'd0);
        check("async_pc", priv_pc, 32'h0);
        step();
        RST = 1'b0; pipe_clear = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_quiet", {31'b0, insert_pc}, 32'd0);
        end

        // vectored / mode-handling cases
`ifdef PRIV_VECTORED_MTVEC_EN
        fire_trap(32'h0000_0201, 32'h8000_0007, 32'h0000_021C, "vec_irq");
        fire_trap(32'h0000_0201, 32'h0000_0002, 32'h0000_0200, "vec_exc");
        fire_trap(32'h0000_0202, 32'h8000_0007, 32'h0000_0200, "vec_mode2");
        fire_trap(32'hFFFF_FFFD, 32'h8000_001F, 32'h0000_0078, "vec_wrap");
`else
        fire_trap(32'h0000_0201, 32'h8000_0007, 32'h0000_0200, "novec_irq");
        fire_trap(32'h0000_0201, 32'h0000_0002, 32'h0000_0200, "novec_exc");
        fire_trap(32'hFFFF_FFFD, 32'h8000_001F, 32'hFFFF_FFFC, "novec_top");
`endif
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
